// File: rtl/bram_arb_pkg.sv
// Shared constants and payload type for the two-port BRAM Wishbone arbiter.
package bram_arb_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] ACK   = 2'd3;

  // Requester indices
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_ACC = 1'b1;

  localparam int unsigned DEFAULT_DELAY  = 10;
  localparam int unsigned DEFAULT_ADDR_W = 10;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned SEL_W          = 4;

  // One Wishbone request as seen by the arbiter
  typedef struct packed {
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] adr;
    logic [DATA_W-1:0] dat;
  } wb_req_t;

endpackage

// File: rtl/bram_arb_rr2.sv
// Two-requester grant logic: round-robin on ties, or fixed CPU priority
// when BRAM_ARB_FIXED_PRIO_EN is defined.
module bram_arb_rr2
  import bram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant_c
);

`ifdef BRAM_ARB_FIXED_PRIO_EN
  // Pointer is irrelevant when the CPU always wins
  logic unused_last;
  assign unused_last = last;

  // CPU first, accelerator only when the CPU is quiet
  always_comb begin
    grant_c = 2'b00;
    if (req[PORT_CPU]) begin
      grant_c[PORT_CPU] = 1'b1;
    end else if (req[PORT_ACC]) begin
      grant_c[PORT_ACC] = 1'b1;
    end
  end
`else
  // Lone requester wins; on a tie the port that did not win last time wins
  always_comb begin
    grant_c = 2'b00;
    if (req[PORT_CPU] && req[PORT_ACC]) begin
      if (last == PORT_CPU) grant_c[PORT_ACC] = 1'b1;
      else                  grant_c[PORT_CPU] = 1'b1;
    end else if (req[PORT_CPU]) begin
      grant_c[PORT_CPU] = 1'b1;
    end else if (req[PORT_ACC]) begin
      grant_c[PORT_ACC] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/bram_wb_arbiter.sv
// Shares one single-port BRAM between the management-core Wishbone path
// (port 0) and the accelerator master (port 1). Sequences each access
// against the BRAM read latency and returns a one-cycle ack per port.
// Build option: BRAM_ARB_FIXED_PRIO_EN selects fixed CPU priority.
module bram_wb_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned DELAY  = DEFAULT_DELAY,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              s0_cyc,
  input  logic              s0_stb,
  input  logic              s0_we,
  input  logic [3:0]        s0_sel,
  input  logic [31:0]       s0_adr,
  input  logic [31:0]       s0_dat_i,
  output logic [31:0]       s0_dat_o,
  output logic              s0_ack,
  input  logic              s1_cyc,
  input  logic              s1_stb,
  input  logic              s1_we,
  input  logic [3:0]        s1_sel,
  input  logic [31:0]       s1_adr,
  input  logic [31:0]       s1_dat_i,
  output logic [31:0]       s1_dat_o,
  output logic              s1_ack,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wdata,
  input  logic [31:0]       bram_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = (DELAY > 1) ? $clog2(DELAY) : 1;

  logic [1:0]        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              last, last_d;
  logic              win, win_d;
  logic              wr, wr_d;
  logic              bram_en_d;
  logic [3:0]        bram_we_d;
  logic [ADDR_W-1:0] bram_addr_d;
  logic [31:0]       bram_wdata_d;
  logic [31:0]       s0_dat_d, s1_dat_d;
  logic              s0_ack_d, s1_ack_d;
  logic              busy_d;
  logic [1:0]        req, grant;
  wb_req_t           s0_req, s1_req, req_sel;
  logic              win_cyc;
  logic              unused_adr;

  assign req[PORT_CPU] = s0_cyc & s0_stb;
  assign req[PORT_ACC] = s1_cyc & s1_stb;
  assign s0_req  = '{we: s0_we, sel: s0_sel, adr: s0_adr, dat: s0_dat_i};
  assign s1_req  = '{we: s1_we, sel: s1_sel, adr: s1_adr, dat: s1_dat_i};
  assign req_sel = grant[PORT_ACC] ? s1_req : s0_req;
  assign win_cyc = (win == PORT_ACC) ? s1_cyc : s0_cyc;

  // Byte-offset and out-of-range address bits are not decoded here
  assign unused_adr = ^{req_sel.adr[31:ADDR_W+2], req_sel.adr[1:0]};

  bram_arb_rr2 u_rr2 (
    .req     (req),
    .last    (last),
    .grant_c (grant)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    last_d       = last;
    win_d        = win;
    wr_d         = wr;
    bram_en_d    = 1'b0;
    bram_we_d    = 4'b0000;
    bram_addr_d  = bram_addr;
    bram_wdata_d = bram_wdata;
    s0_dat_d     = s0_dat_o;
    s1_dat_d     = s1_dat_o;
    s0_ack_d     = 1'b0;
    s1_ack_d     = 1'b0;
    case (state)
      IDLE: begin
        if (|grant) begin
          win_d        = grant[PORT_ACC] ? PORT_ACC : PORT_CPU;
          last_d       = grant[PORT_ACC] ? PORT_ACC : PORT_CPU;
          wr_d         = req_sel.we;
          bram_en_d    = 1'b1;
          bram_we_d    = req_sel.we ? req_sel.sel : 4'b0000;
          bram_addr_d  = req_sel.adr[ADDR_W+1:2];
          bram_wdata_d = req_sel.dat;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = CNT_W'(DELAY - 1);
        if (wr) begin
          s0_ack_d = win_cyc && (win == PORT_CPU);
          s1_ack_d = win_cyc && (win == PORT_ACC);
          state_d  = ACK;
        end else begin
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          if (win == PORT_ACC) s1_dat_d = bram_rdata;
          else                 s0_dat_d = bram_rdata;
          s0_ack_d = win_cyc && (win == PORT_CPU);
          s1_ack_d = win_cyc && (win == PORT_ACC);
          state_d  = ACK;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state      <= IDLE;
      cnt        <= '0;
      last       <= PORT_ACC;
      win        <= PORT_CPU;
      wr         <= 1'b0;
      bram_en    <= 1'b0;
      bram_we    <= 4'b0000;
      bram_addr  <= '0;
      bram_wdata <= '0;
      s0_dat_o   <= '0;
      s1_dat_o   <= '0;
      s0_ack     <= 1'b0;
      s1_ack     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      last       <= last_d;
      win        <= win_d;
      wr         <= wr_d;
      bram_en    <= bram_en_d;
      bram_we    <= bram_we_d;
      bram_addr  <= bram_addr_d;
      bram_wdata <= bram_wdata_d;
      s0_dat_o   <= s0_dat_d;
      s1_dat_o   <= s1_dat_d;
      s0_ack     <= s0_ack_d;
      s1_ack     <= s1_ack_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_bram_wb_arbiter.sv
// Scoreboard bench for bram_wb_arbiter with a behavioural BRAM model.
module tb_bram_wb_arbiter;

  localparam int unsigned DELAY  = 10;
  localparam int unsigned ADDR_W = 10;

  logic              clock  = 1'b0;
  logic              resetb = 1'b1;
  logic              s0_cyc, s0_stb, s0_we, s0_ack;
  logic [3:0]        s0_sel;
  logic [31:0]       s0_adr, s0_dat_i, s0_dat_o;
  logic              s1_cyc, s1_stb, s1_we, s1_ack;
  logic [3:0]        s1_sel;
  logic [31:0]       s1_adr, s1_dat_i, s1_dat_o;
  logic              bram_en, busy;
  logic [3:0]        bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [31:0]       bram_wdata, bram_rdata;

  bram_wb_arbiter #(.DELAY(DELAY), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .resetb(resetb),
    .s0_cyc(s0_cyc), .s0_stb(s0_stb), .s0_we(s0_we), .s0_sel(s0_sel),
    .s0_adr(s0_adr), .s0_dat_i(s0_dat_i), .s0_dat_o(s0_dat_o), .s0_ack(s0_ack),
    .s1_cyc(s1_cyc), .s1_stb(s1_stb), .s1_we(s1_we), .s1_sel(s1_sel),
    .s1_adr(s1_adr), .s1_dat_i(s1_dat_i), .s1_dat_o(s1_dat_o), .s1_ack(s1_ack),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  int en_cnt  = 0;
  int ack_cnt0 = 0;
  int ack_cnt1 = 0;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  // BRAM model: byte-lane writes, reads valid DELAY cycles after bram_en
  logic [31:0] mem [1 << ADDR_W];
  logic [31:0] pipe_d [DELAY];
  bit          pipe_v [DELAY];
  bit          mem_ready = 1'b0;

  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= 32'h1000_0000 + i;
      mem[4]    <= 32'hDEAD_BEEF;
      mem[8]    <= 32'hA5A5_A5A5;
      mem_ready <= 1'b1;
    end else if (bram_en) begin
      en_cnt <= en_cnt + 1;
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_addr][b*8 +: 8] <= bram_wdata[b*8 +: 8];
    end
    pipe_d[0] <= mem[bram_addr];
    pipe_v[0] <= bram_en && (bram_we == 4'b0000);
    for (int i = 1; i < DELAY; i++) begin
      pipe_d[i] <= pipe_d[i-1];
      pipe_v[i] <= pipe_v[i-1];
    end
  end

  assign bram_rdata = pipe_v[DELAY-1] ? pipe_d[DELAY-1] : 32'hBAD0_BAD0;

  typedef struct { logic [31:0] dat; int cyc; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc_cnt);
    end
  endtask

  // Monitor: every ack pops the expected response for that port
  always @(negedge clock) begin
    exp_t e;
    if (s0_ack) begin
      ack_cnt0++;
      if (q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL s0_unexpected_ack: got ack at cycle %0d expected none", cyc_cnt);
      end else begin
        e = q0.pop_front();
        check32("s0_dat_o", s0_dat_o, e.dat);
        check32("s0_ack_cycle", 32'(cyc_cnt), 32'(e.cyc));
      end
    end
    if (s1_ack) begin
      ack_cnt1++;
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL s1_unexpected_ack: got ack at cycle %0d expected none", cyc_cnt);
      end else begin
        e = q1.pop_front();
        check32("s1_dat_o", s1_dat_o, e.dat);
        check32("s1_ack_cycle", 32'(cyc_cnt), 32'(e.cyc));
      end
    end
  end

  task automatic drive(input int p, input logic cyc, input logic stb, input logic we,
                       input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    if (p == 0) begin
      s0_cyc = cyc; s0_stb = stb; s0_we = we; s0_sel = sel; s0_adr = adr; s0_dat_i = dat;
    end else begin
      s1_cyc = cyc; s1_stb = stb; s1_we = we; s1_sel = sel; s1_adr = adr; s1_dat_i = dat;
    end
  endtask

  // One transaction; called just after a rising edge. hold keeps the request
  // asserted so the next call presents a back-to-back request.
  task automatic xfer(input int p, input logic we, input logic [3:0] sel,
                      input logic [31:0] adr, input logic [31:0] dat,
                      input logic [31:0] want, input int lat, input bit hold);
    exp_t e;
    bit got;
    got = 1'b0;
    drive(p, 1'b1, 1'b1, we, sel, adr, dat);
    e.dat = want;
    e.cyc = cyc_cnt + lat;
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    for (int i = 0; i < lat + 20 && !got; i++) begin
      @(negedge clock);
      got = (p == 0) ? s0_ack : s1_ack;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL port%0d_ack_timeout: got no ack expected one at cycle %0d", p, e.cyc);
    end
    @(posedge clock); #1;
    if (!hold) drive(p, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  int en0, acks0, t0;
  int la0, la1, lb0, lb1;

  initial begin
    drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #2 resetb = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check32("rst_bram_en", 32'(bram_en), 0);
    check32("rst_bram_we", 32'(bram_we), 0);
    check32("rst_bram_addr", 32'(bram_addr), 0);
    check32("rst_bram_wdata", bram_wdata, 0);
    check32("rst_s0_dat_o", s0_dat_o, 0);
    check32("rst_s1_dat_o", s1_dat_o, 0);
    check32("rst_acks", {30'b0, s1_ack, s0_ack}, 0);
    check32("rst_busy", 32'(busy), 0);
    @(negedge clock) resetb = 1'b1;
    idle(2);
    check32("post_rst_busy", 32'(busy), 0);

    // Port 0 read of word 4
    en0 = en_cnt;
    fork
      xfer(0, 1'b0, 4'hF, 32'h3800_0010, 32'h0, 32'hDEAD_BEEF, DELAY + 2, 1'b0);
      begin
        @(negedge clock); @(negedge clock);
        check32("rd_t1_bram_en", 32'(bram_en), 1);
        check32("rd_t1_bram_addr", 32'(bram_addr), 4);
        check32("rd_t1_bram_we", 32'(bram_we), 0);
        check32("rd_t1_busy", 32'(busy), 1);
        @(negedge clock);
        check32("rd_t2_bram_en", 32'(bram_en), 0);
      end
    join
    idle(1);
    check32("rd_en_pulses", 32'(en_cnt - en0), 1);

    // Port 1 partial write to word 8, then read it back
    fork
      xfer(1, 1'b1, 4'b0011, 32'h3800_0020, 32'h1234_5678, 32'h0, 2, 1'b0);
      begin
        @(negedge clock); @(negedge clock);
        check32("wr_t1_bram_en", 32'(bram_en), 1);
        check32("wr_t1_bram_we", 32'(bram_we), 32'h3);
        check32("wr_t1_bram_addr", 32'(bram_addr), 8);
        check32("wr_t1_bram_wdata", bram_wdata, 32'h1234_5678);
      end
    join
    idle(1);
    xfer(1, 1'b0, 4'hF, 32'h3800_0020, 32'h0, 32'hA5A5_5678, DELAY + 2, 1'b0);
    check32("s0_dat_o_held", s0_dat_o, 32'hDEAD_BEEF);
    idle(2);

    // Both ports request back-to-back reads simultaneously
`ifdef BRAM_ARB_FIXED_PRIO_EN
    la0 = DELAY + 2; la1 = DELAY + 2; lb0 = 3 * DELAY + 8; lb1 = DELAY + 2;
`else
    la0 = DELAY + 2; la1 = 2 * DELAY + 5; lb0 = 2 * DELAY + 5; lb1 = 2 * DELAY + 5;
`endif
    fork
      begin
        xfer(0, 1'b0, 4'hF, 32'h3800_0004, 32'h0, 32'h1000_0001, la0, 1'b1);
        xfer(0, 1'b0, 4'hF, 32'h3800_0008, 32'h0, 32'h1000_0002, la1, 1'b0);
      end
      begin
        xfer(1, 1'b0, 4'hF, 32'h3800_000C, 32'h0, 32'h1000_0003, lb0, 1'b1);
        xfer(1, 1'b0, 4'hF, 32'h3800_0014, 32'h0, 32'h1000_0005, lb1, 1'b0);
      end
    join
    idle(2);

    // Port 0 abandons its read mid-wait; port 1 waits then is served
    acks0 = ack_cnt0;
    fork
      begin
        drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h3800_0010, 32'h0);
        t0 = cyc_cnt;
        repeat (5) @(posedge clock);
        #1 drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      end
      begin
        idle(3);
        xfer(1, 1'b0, 4'hF, 32'h3800_0018, 32'h0, 32'h1000_0006, 2 * DELAY + 2, 1'b0);
      end
      begin
        repeat (DELAY + 3) @(negedge clock);
        check32("drop_ack_cycle_busy", 32'(busy), 1);
        @(negedge clock);
        check32("drop_idle_busy", 32'(busy), 0);
      end
    join
    check32("drop_no_s0_ack", 32'(ack_cnt0 - acks0), 0);
    idle(2);

    // Reset pulse during a read wait, then a fresh read
    acks0 = ack_cnt0;
    drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h3800_001C, 32'h0);
    repeat (6) @(posedge clock);
    #3 resetb = 1'b0;
    #1;
    check32("arst_bram_en", 32'(bram_en), 0);
    check32("arst_busy", 32'(busy), 0);
    check32("arst_bram_addr", 32'(bram_addr), 0);
    check32("arst_s0_dat_o", s0_dat_o, 0);
    check32("arst_s1_dat_o", s1_dat_o, 0);
    drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clock) resetb = 1'b1;
    idle(DELAY + 4);
    check32("arst_no_ack", 32'(ack_cnt0 - acks0), 0);
    xfer(0, 1'b0, 4'hF, 32'h3800_001C, 32'h0, 32'h1000_0007, DELAY + 2, 1'b0);
    check32("arst_one_ack_after", 32'(ack_cnt0 - acks0), 1);
    idle(2);

    check32("q0_drained", 32'(q0.size()), 0);
    check32("q1_drained", 32'(q1.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_wb_arbiter.md
# bram_wb_arbiter

Shares the single-port user-project BRAM (firmware code/data, executed from user space) between two Wishbone requesters: port 0 is the management-core Wishbone path from the user project wrapper, port 1 is the on-chip accelerator/DMA master (FIR/matmul engine). The block arbitrates, sequences each access against the BRAM's fixed read latency and generates per-port acks. It sits between the wrapper's address decode and the BRAM macro.

## Interface
- DELAY, 10, BRAM read latency in cycles from `bram_en` to valid `bram_rdata` (≥1)
- ADDR_W, 10, BRAM word-address width (4 KB at default)
- clock  in  1  system clock; all logic on rising edge
- resetb  in  1  reset, asynchronous, active-low
- s0_cyc, s0_stb, s0_we  in  1 each  port 0 Wishbone controls (already address-decoded)
- s0_sel  in  4  byte lanes
- s0_adr  in  32  byte address; bits [ADDR_W+1:2] used
- s0_dat_i  in  32  write data
- s0_dat_o  out  32  read data, registered
- s0_ack  out  1  single-cycle ack
- s1_*  same set as s0_*, for port 1
- bram_en  out  1  BRAM access strobe, one cycle per transaction
- bram_we  out  4  byte write enables (zero on reads)
- bram_addr  out  ADDR_W  word address
- bram_wdata  out  32  write data
- bram_rdata  in  32  read data, valid DELAY cycles after bram_en
- busy  out  1  high in any state other than IDLE

## Operation
- Request on port n: `sn_cyc & sn_stb`.
- FSM: IDLE → ISSUE → (read: WAIT → ACK; write: ACK) → IDLE.
- IDLE: if any request, pick winner, latch adr/we/sel/wdata into internal registers, → ISSUE.
- ISSUE: drive `bram_en=1`, `bram_we = we ? sel : 0`, latched addr/wdata for exactly one cycle; load wait counter with DELAY-1.
- WAIT: decrement counter; at 0 capture `bram_rdata` into winner's `sn_dat_o`, → ACK.
- ACK: assert `sn_ack` of winner for one cycle, only if `sn_cyc` is still high; else suppress ack (transaction completes silently). → IDLE.
- Arbitration: round-robin, one transaction per grant; pointer `last` records last winner. Both requesting → grant port ≠ `last`. After reset `last=1`, so port 0 wins first tie.
- Non-granted port simply stalls (no ack) until served; its inputs are not sampled.
- `sn_dat_o` holds last value read for that port; unaffected by the other port's transactions.

## Timing
- Reset values: all acks 0, `bram_en` 0, `bram_we` 0, `bram_addr` 0, `bram_wdata` 0, `s0_dat_o`/`s1_dat_o` 0, `busy` 0, state IDLE, `last`=1.
- Request visible in cycle T0 (IDLE) → `bram_en` at T1.
- Read: data valid at T1+DELAY, captured that edge, ack at T2+DELAY. DELAY=10: ack at T12.
- Write: ack at T2.
- Back-to-back: next IDLE decision on cycle after ACK; minimum read period DELAY+3 cycles, write period 3 cycles.
- Master must deassert stb the cycle after ack; a stb still high in IDLE is a new request.
- `resetb` low mid-transaction: immediate return to IDLE, all outputs to reset values, no ack issued; BRAM output ignored.

## Configuration
- `BRAM_ARB_FIXED_PRIO_EN` defined: port 0 (CPU) always wins ties; `last` pointer unused. Guarantees firmware fetch latency; port 1 may starve.
- Undefined (default): round-robin as above.

## Structure
- Package `bram_arb_pkg`: FSM state enum (IDLE, ISSUE, WAIT, ACK), port index constants `PORT_CPU=0`, `PORT_ACC=1`, default DELAY constant.
- One sub-module `bram_arb_rr2`: 2-requester grant logic (requests, `last`, fixed-prio switch → one-hot grant); FSM, counter and datapath stay in top.

## Test plan
- Port 0 read of 0x3800_0010 (word 4 preloaded 0xDEADBEEF), DELAY=10 → `bram_en` once at T1 with addr 4, `s0_ack` at T12, `s0_dat_o`=0xDEADBEEF.
- Port 1 write 0x12345678 to word 8 with sel=4'b0011 → `bram_we`=4'b0011 at T1, `s1_ack` at T2; subsequent read returns 0x????5678 with upper bytes unchanged.
- Both ports request reads continuously from reset → grants alternate 0,1,0,1; with `BRAM_ARB_FIXED_PRIO_EN` port 0 served every transaction, port 1 never acked while port 0 requests.
- Port 0 drops `cyc` during WAIT → no `s0_ack`, FSM reaches IDLE at expected cycle, port 1 pending request then served normally.
- `resetb` pulsed low during WAIT → outputs at reset values asynchronously, no ack; after release, a new read completes with correct latency.
- DELAY=1 build: read ack at T3, data correct; writes unaffected.
